// File: rtl/shl_pkg.sv
// Shared constants and the result-register state type for the shifter arbiter.
package shl_pkg;
  localparam int SH_AMT_W  = 5;
  localparam int DATA_W    = 32;
  localparam int N_REQ_MAX = 8;

  typedef enum logic {EMPTY, FULL} rsp_state_t;
endpackage

// File: rtl/shl_arbiter_shl.sv
// 32-bit logical left barrel shifter, zero fill; one log2 stage per shift-amount bit.
module Shl
  import shl_pkg::*;
(
  input  logic [DATA_W-1:0]   data,
  input  logic [SH_AMT_W-1:0] sh_amt,
  output logic [DATA_W-1:0]   result
);

  logic [DATA_W-1:0] stage [SH_AMT_W+1];

  always_comb begin
    stage[0] = data;
    for (int s = 0; s < SH_AMT_W; s++) begin
      stage[s+1] = sh_amt[s] ? (stage[s] << (1 << s)) : stage[s];
    end
    result = stage[SH_AMT_W];
  end

endmodule

// File: rtl/shl_arbiter.sv
// Round-robin arbiter sharing one Shl among N_REQ requesters, with a
// one-entry result register that sustains one shift per cycle.
module shl_arbiter
  import shl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ_VALID,
  input  logic [SH_AMT_W*N_REQ-1:0] REQ_SH_AMT,
  input  logic [DATA_W*N_REQ-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]          REQ_READY,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [ID_W-1:0]           RSP_ID,
  output logic [DATA_W-1:0]         RSP_DATA
);

  rsp_state_t          state_q, state_d;
  logic [ID_W-1:0]     prio;
  logic [ID_W-1:0]     grant_idx;
  logic                found;
  logic                free;
  logic                xfer;
  logic [SH_AMT_W-1:0] mux_sh_amt;
  logic [DATA_W-1:0]   mux_data;
  logic [DATA_W-1:0]   shl_result;

  // Walk from the far end back toward prio so the nearest valid requester wins.
  always_comb begin
    int idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(prio) + k) % N_REQ;
      if (REQ_VALID[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign free = (state_q == EMPTY) || RSP_READY;
  assign xfer = free && found && !RST;

  always_comb begin
    REQ_READY = '0;
    if (xfer) REQ_READY[grant_idx] = 1'b1;
  end

  assign mux_sh_amt = REQ_SH_AMT[int'(grant_idx)*SH_AMT_W +: SH_AMT_W];
  assign mux_data   = REQ_DATA[int'(grant_idx)*DATA_W +: DATA_W];

  Shl u_shl (
    .data   (mux_data),
    .sh_amt (mux_sh_amt),
    .result (shl_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (RSP_READY && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= EMPTY;
      prio     <= '0;
      RSP_ID   <= '0;
      RSP_DATA <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        RSP_DATA <= shl_result;
        RSP_ID   <= grant_idx;
        prio     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign RSP_VALID = (state_q == FULL);

endmodule

// File: tb/tb_shl_arbiter.sv
// Directed, table-driven bench for shl_arbiter with N_REQ=4.
module tb_shl_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   REQ_VALID;
  logic [19:0]  REQ_SH_AMT;
  logic [127:0] REQ_DATA;
  logic [3:0]   REQ_READY;
  logic         RSP_VALID;
  logic         RSP_READY;
  logic [1:0]   RSP_ID;
  logic [31:0]  RSP_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  shl_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_SH_AMT (REQ_SH_AMT),
    .REQ_DATA   (REQ_DATA),
    .REQ_READY  (REQ_READY),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_ID     (RSP_ID),
    .RSP_DATA   (RSP_DATA)
  );

  always #5 CLK = ~CLK;

  // Requester i gets DATA=data and SH_AMT=(sh_base+i) mod 32.
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [4:0]  sh_base;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [31:0] data,
                       input logic [4:0] sh_base, input logic rdy);
    REQ_VALID = valid;
    RSP_READY = rdy;
    for (int i = 0; i < 4; i++) begin
      REQ_SH_AMT[5*i +: 5] = 5'(sh_base + 5'(i));
      REQ_DATA[32*i +: 32] = data;
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 32'h1,         5'd4,  1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0010};
    vecs[1]  = '{4'b1000, 32'h1,         5'd0,  1'b1, 4'b1000, 1'b1, 2'd3, 32'h0000_0008};
    vecs[2]  = '{4'b1111, 32'h1,         5'd0,  1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0001};
    vecs[3]  = '{4'b1110, 32'h1,         5'd0,  1'b1, 4'b0010, 1'b1, 2'd1, 32'h0000_0002};
    vecs[4]  = '{4'b1100, 32'h1,         5'd0,  1'b1, 4'b0100, 1'b1, 2'd2, 32'h0000_0004};
    vecs[5]  = '{4'b1000, 32'h1,         5'd0,  1'b1, 4'b1000, 1'b1, 2'd3, 32'h0000_0008};
    vecs[6]  = '{4'b0000, 32'h1,         5'd0,  1'b1, 4'b0000, 1'b0, 2'd3, 32'h0000_0008};
    vecs[7]  = '{4'b0001, 32'hFFFF_FFFF, 5'd31, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h8000_0000};
    vecs[8]  = '{4'b0001, 32'hFFFF_FFFF, 5'd0,  1'b1, 4'b0001, 1'b1, 2'd0, 32'hFFFF_FFFF};
    vecs[9]  = '{4'b0110, 32'h1,         5'd0,  1'b0, 4'b0000, 1'b1, 2'd0, 32'hFFFF_FFFF};
    vecs[10] = '{4'b0110, 32'h1,         5'd0,  1'b0, 4'b0000, 1'b1, 2'd0, 32'hFFFF_FFFF};
    vecs[11] = '{4'b0110, 32'h1,         5'd0,  1'b0, 4'b0000, 1'b1, 2'd0, 32'hFFFF_FFFF};
    vecs[12] = '{4'b0110, 32'h1,         5'd0,  1'b1, 4'b0010, 1'b1, 2'd1, 32'h0000_0002};

    RST = 1'b1;
    drive(4'b1111, 32'h1, 5'd0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset req_ready", 32'(REQ_READY), 32'h0);
    chk("reset rsp_valid", 32'(RSP_VALID), 32'h0);
    chk("reset rsp_id",    32'(RSP_ID),    32'h0);
    chk("reset rsp_data",  RSP_DATA,       32'h0);
    RST = 1'b0;
    drive(4'b0000, 32'h0, 5'd0, 1'b1);
    @(posedge CLK);
    #1;

    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].valid, vecs[v].data, vecs[v].sh_base, vecs[v].rdy);
      #1;
      chk($sformatf("v%0d req_ready", v), 32'(REQ_READY), 32'(vecs[v].exp_ready));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d rsp_valid", v), 32'(RSP_VALID), 32'(vecs[v].exp_valid));
      chk($sformatf("v%0d rsp_id", v),    32'(RSP_ID),    32'(vecs[v].exp_id));
      chk($sformatf("v%0d rsp_data", v),  RSP_DATA,       vecs[v].exp_data);
    end

    // FULL with prio=2: an asynchronous reset mid-cycle must clear everything at once.
    drive(4'b1111, 32'h1, 5'd0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst rsp_valid", 32'(RSP_VALID), 32'h0);
    chk("midrst rsp_data",  RSP_DATA,       32'h0);
    chk("midrst rsp_id",    32'(RSP_ID),    32'h0);
    chk("midrst req_ready", 32'(REQ_READY), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    RSP_READY = 1'b1;
    #1;
    chk("post-rst grant", 32'(REQ_READY), 32'h1);
    @(posedge CLK);
    #1;
    chk("post-rst rsp_valid", 32'(RSP_VALID), 32'h1);
    chk("post-rst rsp_id",    32'(RSP_ID),    32'h0);
    chk("post-rst rsp_data",  RSP_DATA,       32'h1);
    #1;
    chk("post-rst next grant", 32'(REQ_READY), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
